seg_scan_ctrl: RTL and testbench
================================

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- N_DIG, 8, number of multiplexed digits (fixed at 8 for this revision).
- TICK_DIV, 50000, clk cycles each digit is driven.
- DEAD, 4, all-off clk cycles between digits (anti-ghosting), DEAD >= 1.

REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  scan enable.
- load  in  1  one-cycle strobe: capture data.
- data  in  32  eight hex nibbles; digit k = data[4k+3:4k], digit 7 most significant.
- lz_en  in  1  leading-zero blanking enable.
- dp  in  8  decimal point request per digit, active-high.
- seg_in  in  8  active-low pattern from the shared hex-to-7seg decoder; bit0 = dp segment.
- nib  out  4  nibble presented to the shared decoder.
- seg_out  out  8  active-low segment drive.
- an  out  8  active-low digit select, at most one bit low.
- frame  out  1  one-cycle pulse at each frame start (idx wraps to 0).
- pending  out  1  new data waiting for the frame boundary.

Function
REQ-003 The controller SHALL own one decoder instance and time-share it: nib = shadow[4*idx+3:4*idx], combinational from the registered idx.
REQ-004 The FSM SHALL have states OFF, SHOW and DEAD, with a tick counter and a 3-bit digit index idx.
REQ-005 In OFF: an = 8'hFF and seg_out = 8'hFF; with en=1 the FSM SHALL go to SHOW on the next edge with idx=0.
REQ-006 In SHOW: an[idx] = 0, others 1; seg_out[7:1] = seg_in[7:1] (8'hFF[7:1] when the digit is blanked); seg_out[0] = ~dp[idx].
REQ-007 SHOW SHALL last exactly TICK_DIV cycles, then go to DEAD with the counter cleared.
REQ-008 DEAD SHALL hold an = 8'hFF and seg_out = 8'hFF for exactly DEAD cycles, then go to SHOW with idx <= idx+1 mod 8.
REQ-009 Digit period SHALL be TICK_DIV+DEAD cycles; frame period SHALL be 8*(TICK_DIV+DEAD) cycles.
REQ-010 en=0 in any state SHALL force OFF on the next edge, with idx=0 and the counter cleared.
REQ-011 Leading-zero blanking: with lz_en=1, digit k (k>=1) SHALL be blanked iff nibbles 7..k of shadow are all zero; digit 0 SHALL never be blanked; dp SHALL still follow REQ-006.
REQ-012 load=1 outside OFF SHALL capture data into a pending register and set pending=1; a later load before commit SHALL overwrite it (last wins).
REQ-013 Commit SHALL occur on the DEAD->SHOW edge where idx wraps 7->0: shadow <= pending register, pending <= 0, and frame=1 during the first SHOW cycle of idx 0.
REQ-014 load coincident with the commit edge SHALL write data directly into shadow and leave pending=0.
REQ-015 load=1 in OFF SHALL write shadow immediately, leaving pending=0.
REQ-016 Entry from OFF into SHOW SHALL also assert frame for one cycle.
REQ-017 Changing shadow mid-frame SHALL NOT occur; all displayed digits in one frame SHALL come from a single shadow value.

Reset
REQ-018 rst_n=0 SHALL immediately, asynchronously and independent of clk, set: state=OFF, idx=0, counter=0, shadow=0, pending register=0, pending=0, frame=0, an=8'hFF, seg_out=8'hFF.
REQ-019 After rst_n deasserts, the first SHOW SHALL occur at the first edge with en=1.

Verification (TICK_DIV=4, DEAD=2)
REQ-020 The bench SHALL cover these directed scenarios:
- Reset: assert rst_n=0 mid-SHOW between edges -> an=8'hFF and seg_out=8'hFF within the same cycle; pending=0.
- Scan: load 0x12345678 in OFF, then en=1 -> an=FE for 4 cycles, FF for 2, then FD...; nib=8,7,6,...,1; frame pulses every 48 cycles.
- Blanking: lz_en=1, shadow 0x00000A05 -> digits 7..3 seg_out=8'hFF, digits 2..0 decode A,0,5; shadow 0 -> only digit 0 lit, showing "0"; dp[5]=1 -> digit 5 seg_out=8'hFE.
- Deferred update: load 0xFFFFFFFF at idx=3 -> pending=1; digits 3..7 still old; first SHOW after frame shows F; pending=0.
- Collision: load 0x11111111 at idx=2, then load 0x22222222 on the commit edge -> next frame shows 2 on all digits; pending=0.
- Enable drop: en=0 during DEAD -> OFF next edge with an=8'hFF; en=1 again -> restarts at idx=0 with a frame pulse.

Source files
------------

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle between the digit scan controller and its surroundings:
// control inputs, the shared decoder loop and the display drive.
interface seg_scan_ctrl_if;
    logic        en;
    logic        load;
    logic [31:0] data;
    logic        lz_en;
    logic [7:0]  dp;
    logic [7:0]  seg_in;
    logic [3:0]  nib;
    logic [7:0]  seg_out;
    logic [7:0]  an;
    logic        frame;
    logic        pending;

    modport master (
        output en, load, data, lz_en, dp, seg_in,
        input  nib, seg_out, an, frame, pending
    );

    modport slave (
        input  en, load, data, lz_en, dp, seg_in,
        output nib, seg_out, an, frame, pending
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 8-digit 7-segment scan controller: time-shares one hex decoder,
// inserts dead time between digits and only swaps displayed data at frame starts.
module seg_scan_ctrl #(
    parameter int N_DIG    = 8,
    parameter int TICK_DIV = 50000,
    parameter int DEAD     = 4
) (
    input logic            clk,
    input logic            rst_n,
    seg_scan_ctrl_if.slave bus
);
    localparam int CW = $clog2(TICK_DIV + DEAD + 1);

    typedef enum logic [1:0] {S_OFF, S_SHOW, S_DEAD} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    idx, idx_nxt;
    logic          frame, frame_nxt;
    logic          commit;
    logic [31:0]   shadow, pend_data;
    logic          pend;
    logic          blank;
    logic          unused_dec_dp;

    // The decoder's own dp segment is replaced by the per-digit dp request.
    assign unused_dec_dp = bus.seg_in[0];

    assign bus.nib     = shadow[{idx, 2'b00} +: 4];
    assign bus.frame   = frame;
    assign bus.pending = pend;

    assign blank = bus.lz_en && (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        frame_nxt = 1'b0;
        commit    = 1'b0;
        if (!bus.en) begin
            state_nxt = S_OFF;
            cnt_nxt   = '0;
            idx_nxt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    state_nxt = S_SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = '0;
                    frame_nxt = 1'b1;
                end
                S_SHOW: begin
                    if (cnt == CW'(TICK_DIV - 1)) begin
                        state_nxt = S_DEAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                S_DEAD: begin
                    if (cnt == CW'(DEAD - 1)) begin
                        state_nxt = S_SHOW;
                        cnt_nxt   = '0;
                        if (idx == 3'(N_DIG - 1)) begin
                            idx_nxt   = '0;
                            commit    = 1'b1;
                            frame_nxt = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        bus.an      = 8'hFF;
        bus.seg_out = 8'hFF;
        if (state == S_SHOW) begin
            bus.an[idx] = 1'b0;
            bus.seg_out = {blank ? 7'h7F : bus.seg_in[7:1], ~bus.dp[idx]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_OFF;
            cnt   <= '0;
            idx   <= '0;
            frame <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            frame <= frame_nxt;
        end
    end

    // New data is parked until the frame wraps so one frame never mixes two values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow    <= '0;
            pend_data <= '0;
            pend      <= 1'b0;
        end else if (state == S_OFF) begin
            if (bus.load) begin
                shadow <= bus.data;
                pend   <= 1'b0;
            end
        end else if (commit) begin
            if (bus.load)
                shadow <= bus.data;
            else if (pend)
                shadow <= pend_data;
            pend <= 1'b0;
        end else if (bus.load) begin
            pend_data <= bus.data;
            pend      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a frame-time reference model checks every cycle,
// plus a hand-filled vector table and directed multi-cycle scenarios.
module tb_seg_scan_ctrl;
    localparam int TICK   = 4;
    localparam int DEADC  = 2;
    localparam int DIGP   = TICK + DEADC;
    localparam int FRAMEP = 8 * DIGP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seg_scan_ctrl_if bus ();

    seg_scan_ctrl #(.N_DIG(8), .TICK_DIV(TICK), .DEAD(DEADC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit          m_on;
    int          m_t;
    logic [31:0] m_shadow;
    logic [31:0] m_pendv;
    bit          m_pend;
    bit          cur_lz;
    logic [7:0]  cur_dp;

    typedef struct {
        bit          en;
        bit          load;
        logic [31:0] data;
        logic [7:0]  an;
        logic [7:0]  seg;
        logic [3:0]  nib;
        bit          frame;
    } vec_t;

    vec_t vec[10];

    // Active-high gfedcba patterns; the emulated shared decoder inverts them.
    function automatic logic [6:0] segPat(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    assign bus.seg_in = {~segPat(bus.nib), 1'b1};

    task automatic modelReset();
        m_on = 0; m_t = 0; m_shadow = '0; m_pendv = '0; m_pend = 0;
    endtask

    task automatic modelStep();
        bit commit;
        commit = m_on && (m_t == FRAMEP - 1) && bus.en;
        if (!m_on) begin
            if (bus.load) begin m_shadow = bus.data; m_pend = 0; end
        end else if (commit) begin
            if (bus.load) m_shadow = bus.data;
            else if (m_pend) m_shadow = m_pendv;
            m_pend = 0;
        end else if (bus.load) begin
            m_pendv = bus.data; m_pend = 1;
        end
        if (!bus.en) begin m_on = 0; m_t = 0; end
        else if (!m_on) begin m_on = 1; m_t = 0; end
        else m_t = (m_t + 1) % FRAMEP;
    endtask

    task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        int         d;
        bit         show;
        bit         blank;
        logic [3:0] enib;
        logic [7:0] ean;
        logic [7:0] eseg;
        d     = m_t / DIGP;
        show  = m_on && ((m_t % DIGP) < TICK);
        enib  = 4'(m_shadow >> (4 * d));
        blank = bus.lz_en && (d != 0) && ((m_shadow >> (4 * d)) == 32'd0);
        ean   = show ? ~(8'h01 << d) : 8'hFF;
        eseg  = show ? {blank ? 7'h7F : ~segPat(enib), ~bus.dp[d]} : 8'hFF;
        checkField({tag, ".an"}, 32'(bus.an), 32'(ean));
        checkField({tag, ".seg_out"}, 32'(bus.seg_out), 32'(eseg));
        checkField({tag, ".nib"}, 32'(bus.nib), 32'(enib));
        checkField({tag, ".frame"}, 32'(bus.frame), 32'(m_on && m_t == 0));
        checkField({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
    endtask

    task automatic applyStimulus(input bit e, input bit l, input logic [31:0] d,
                                 input bit lz, input logic [7:0] p);
        bus.en = e; bus.load = l; bus.data = d; bus.lz_en = lz; bus.dp = p;
    endtask

    task automatic doCycle(input bit e, input bit l, input logic [31:0] d);
        applyStimulus(e, l, d, cur_lz, cur_dp);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput("model");
        @(negedge clk);
    endtask

    task automatic runUntil(input int target);
        bit hit;
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (m_on && m_t == target) hit = 1;
            else doCycle(1, 0, 32'h0);
        end
        if (!hit) begin
            checks++; errors++;
            $display("[TB] FAIL runUntil timeout: got no t=%0d expected reach within 200 cycles", target);
        end
    endtask

    task automatic cyclesToFrame(output int n);
        n = -1;
        for (int i = 1; i <= 100 && n < 0; i++) begin
            doCycle(1, 0, 32'h0);
            if (bus.frame === 1'b1) n = i;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] rd;
        vec[0] = '{1'b0, 1'b1, 32'h12345678, 8'hFF, 8'hFF, 4'h8, 1'b0};
        vec[1] = '{1'b1, 1'b0, 32'h0, 8'hFE, 8'h01, 4'h8, 1'b1};
        vec[2] = '{1'b1, 1'b0, 32'h0, 8'hFE, 8'h01, 4'h8, 1'b0};
        vec[3] = '{1'b1, 1'b0, 32'h0, 8'hFE, 8'h01, 4'h8, 1'b0};
        vec[4] = '{1'b1, 1'b0, 32'h0, 8'hFE, 8'h01, 4'h8, 1'b0};
        vec[5] = '{1'b1, 1'b0, 32'h0, 8'hFF, 8'hFF, 4'h8, 1'b0};
        vec[6] = '{1'b1, 1'b0, 32'h0, 8'hFF, 8'hFF, 4'h8, 1'b0};
        vec[7] = '{1'b1, 1'b0, 32'h0, 8'hFD, 8'hF1, 4'h7, 1'b0};
        vec[8] = '{1'b1, 1'b0, 32'h0, 8'hFD, 8'hF1, 4'h7, 1'b0};
        vec[9] = '{1'b1, 1'b0, 32'h0, 8'hFD, 8'hF1, 4'h7, 1'b0};

        cur_lz = 0; cur_dp = 8'h00;
        applyStimulus(0, 0, 32'h0, 0, 8'h00);
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst_n = 1'b1;

        // Basic scan from a value loaded while off
        for (int i = 0; i < 10; i++) begin
            doCycle(vec[i].en, vec[i].load, vec[i].data);
            checkField("vec.an", 32'(bus.an), 32'(vec[i].an));
            checkField("vec.seg_out", 32'(bus.seg_out), 32'(vec[i].seg));
            checkField("vec.nib", 32'(bus.nib), 32'(vec[i].nib));
            checkField("vec.frame", 32'(bus.frame), 32'(vec[i].frame));
        end
        cyclesToFrame(n);
        cyclesToFrame(n);
        checkField("frame_period", 32'(n), 32'(FRAMEP));

        // Deferred update
        runUntil(3 * DIGP);
        doCycle(1, 1, 32'hFFFFFFFF);
        checkField("deferred.pending", 32'(bus.pending), 32'd1);
        runUntil(0);
        checkField("deferred.nib", 32'(bus.nib), 32'hF);
        checkField("deferred.pending_clr", 32'(bus.pending), 32'd0);

        // Collision of a load with the commit edge
        runUntil(2 * DIGP);
        doCycle(1, 1, 32'h11111111);
        runUntil(FRAMEP - 1);
        doCycle(1, 1, 32'h22222222);
        checkField("collide.frame", 32'(bus.frame), 32'd1);
        checkField("collide.pending", 32'(bus.pending), 32'd0);
        checkField("collide.nib", 32'(bus.nib), 32'h2);
        runUntil(7 * DIGP);
        checkField("collide.nib7", 32'(bus.nib), 32'h2);

        // Leading-zero blanking
        cur_lz = 1;
        doCycle(0, 0, 32'h0);
        doCycle(0, 1, 32'h00000A05);
        runUntil(7 * DIGP);
        checkField("blank.d7_seg", 32'(bus.seg_out), 32'hFF);
        checkField("blank.d7_an", 32'(bus.an), 32'h7F);
        runUntil(2 * DIGP);
        checkField("blank.d2_seg", 32'(bus.seg_out), 32'h11);
        doCycle(0, 0, 32'h0);
        cur_dp = 8'h20;
        doCycle(0, 1, 32'h0);
        runUntil(0);
        checkField("blank.d0_seg", 32'(bus.seg_out), 32'h81);
        runUntil(DIGP);
        checkField("blank.d1_seg", 32'(bus.seg_out), 32'hFF);
        runUntil(5 * DIGP);
        checkField("blank.d5_dp", 32'(bus.seg_out), 32'hFE);
        checkField("blank.d5_an", 32'(bus.an), 32'hDF);
        cur_lz = 0; cur_dp = 8'h00;

        // Enable drop during dead time, then restart
        runUntil(TICK);
        doCycle(0, 0, 32'h0);
        checkField("endrop.an", 32'(bus.an), 32'hFF);
        doCycle(1, 0, 32'h0);
        checkField("restart.frame", 32'(bus.frame), 32'd1);
        checkField("restart.an", 32'(bus.an), 32'hFE);

        // Asynchronous reset between edges while showing
        runUntil(DIGP);
        doCycle(1, 1, 32'hDEADBEEF);
        checkField("prereset.pending", 32'(bus.pending), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkField("areset.an", 32'(bus.an), 32'hFF);
        checkField("areset.seg_out", 32'(bus.seg_out), 32'hFF);
        checkField("areset.pending", 32'(bus.pending), 32'd0);
        checkField("areset.frame", 32'(bus.frame), 32'd0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("postreset");
        doCycle(1, 0, 32'h0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 800; i++) begin
            rd = $urandom;
            if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(1, 8));
            cur_lz = bit'($urandom_range(0, 1));
            cur_dp = 8'($urandom);
            doCycle($urandom_range(0, 39) != 0, $urandom_range(0, 11) == 0, rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
